hdlc_rx_monitor: RTL and testbench
==================================

HDLC_RX_MONITOR -- requirements
Module: hdlc_rx_monitor

Interface
REQ-001 Parameter N_CH, default 4: number of independent serial Rx channels.
REQ-002 Parameter CNT_W, default 16: width of each saturating event counter.
REQ-003 Parameter MIN_PAYLOAD, default 32: minimum legal payload bits per frame (16 data + 16 FCS).
REQ-004 Parameter MAX_PAYLOAD, default 1024: maximum legal payload bits per frame.
REQ-005 Parameter IDLE_LEN, default 15, legal range 8..15: consecutive ones that declare line idle.
REQ-006 Clk  in  1  single clock; all logic on rising edge.
REQ-007 Rst  in  1  asynchronous, active-high reset.
REQ-008 Rx_En  in  N_CH  per-channel bit strobe; Rx[ch] is sampled only on edges where Rx_En[ch]=1.
REQ-009 Rx  in  N_CH  serial line bits, one per channel.
REQ-010 Cnt_Clr  in  1  synchronous clear of all counters.
REQ-011 Rd_Sel  in  clog2(N_CH) (minimum 1)  channel select for counter read.
REQ-012 Rd_Type  in  2  counter select: 0 = good frames, 1 = aborts, 2 = frame errors, 3 = status.
REQ-013 Rd_Data  out  CNT_W  registered read data.
REQ-014 FlagDetect  out  N_CH  one-cycle pulse per detected flag.
REQ-015 AbortDetect  out  N_CH  one-cycle pulse per detected abort.
REQ-016 FrameOK  out  N_CH  one-cycle pulse when a legal frame closes.
REQ-017 FrameErr  out  N_CH  one-cycle pulse when an illegal frame closes.
REQ-018 Idle  out  N_CH  level, high while the channel is in IDLE.
REQ-019 InFrame  out  N_CH  level, high while the channel is in FRAME.

Function
REQ-020 Each channel SHALL hold a 4-bit saturating ones-run counter R: on a sampled 1, R <= min(R+1, 15); on a sampled 0, R <= 0.
REQ-021 Flag: sampled 0 with R==6 SHALL raise FlagDetect.
REQ-022 Stuffed zero: sampled 0 with R==5 SHALL be removed (not counted as payload).
REQ-023 Abort: sampled 1 with R==6 SHALL raise AbortDetect; this fires at most once per ones-run.
REQ-024 Per-channel FSM states SHALL be HUNT, FRAME and IDLE.
  - Flag in any state -> FRAME, with bit counter B cleared.
  - Abort in FRAME -> HUNT.
  - R reaching IDLE_LEN in HUNT or FRAME -> IDLE.
  - Non-flag 0 in IDLE -> HUNT.
REQ-025 In FRAME, every sampled bit except stuffed zeros and the final 0 of a flag SHALL increment B; B is 11 bits wide and saturates at 2047.
REQ-026 On a flag while in FRAME, payload P = B-7 (the flag's leading 0111111 is discounted).
  - P==0: back-to-back flags; neither FrameOK nor FrameErr.
  - MIN_PAYLOAD<=P<=MAX_PAYLOAD and P%8==0: FrameOK.
  - Otherwise: FrameErr.
REQ-027 An abort in FRAME SHALL NOT raise FrameErr.
REQ-028 All pulses SHALL be asserted for exactly one Clk cycle immediately after the sampling edge of the causing bit.
REQ-029 Channels with Rx_En=0 SHALL hold all state and emit no pulses.
REQ-030 Per channel, counters SHALL count FrameOK, AbortDetect and FrameErr events; each is CNT_W wide and saturates at all-ones (no wrap).
REQ-031 Cnt_Clr SHALL zero all counters of all channels; a clear and an increment in the same cycle yield 0.
REQ-032 Rd_Data SHALL present the selected counter one cycle after Rd_Sel/Rd_Type are sampled.
  - Rd_Type=3 returns {zeros, Idle, InFrame} of the selected channel.
  - Rd_Sel >= N_CH returns 0.
REQ-033 Channels SHALL be fully independent; simultaneous events on multiple channels are all counted in the same cycle.

Reset
REQ-034 Rst asserted SHALL, asynchronously: set all FSMs to HUNT, set R=15, clear B, zero all counters, drive all pulse outputs, Idle, InFrame and Rd_Data to 0.
REQ-035 R=15 at reset SHALL prevent an abort on a high line after reset release; that line reaches IDLE on the first sampled 1.
REQ-036 Reset mid-frame SHALL discard the frame with no FrameOK or FrameErr pulse.

Verification
REQ-037 Ch0: flag, 32 payload bits 0xA5A5A5A5, flag -> FlagDetect x2, FrameOK x1, good counter = 1.
REQ-038 Ch1: flag, 24 bits of data, then 01111111 -> AbortDetect x1, state HUNT, abort counter = 1, no FrameErr.
REQ-039 Ch2: flag, payload 0xFF x4 sent with stuffed zeros, flag -> stuffed zeros removed, P=32, FrameOK.
REQ-040 Ch3: flag, 36-bit payload, flag -> FrameErr (P%8 != 0); then 20 ones -> Idle=1.
REQ-041 Force the abort counter to all-ones, then one more abort -> counter holds all-ones; Cnt_Clr issued in the same cycle as an abort -> 0.
REQ-042 Rst asserted mid-frame on all channels, then released -> all outputs 0, Rd_Data=0 for every channel and type, no spurious pulses.

Source files
------------

// File: rtl/hdlc_rx_monitor.sv
// hdlc_rx_monitor
//   Multi-channel HDLC receive-line monitor. Each channel tracks its ones-run,
//   detects flags, aborts and stuffed zeros, follows a HUNT/FRAME/IDLE state
//   machine, measures the de-stuffed payload length of each closed frame and
//   classifies it as good or bad. Per-channel saturating counters record good
//   frames, aborts and frame errors. Any counter, or the channel status, can be
//   read back through a registered select port.
//
// Ports
//   Clk          rising-edge clock
//   Rst          asynchronous active-high reset
//   Rx_En[N_CH]  per-channel bit strobe; Rx is sampled only where set
//   Rx[N_CH]     serial line bits
//   Cnt_Clr      synchronous clear of every counter (wins over increments)
//   Rd_Sel       channel to read
//   Rd_Type      0 good, 1 aborts, 2 frame errors, 3 status {Idle, InFrame}
//   Rd_Data      registered read data, valid one cycle after the select
//   FlagDetect, AbortDetect, FrameOK, FrameErr  one-cycle event pulses
//   Idle, InFrame                               state levels
module hdlc_rx_monitor #(
  parameter int  N_CH        = 4,
  parameter int  CNT_W       = 16,
  parameter int  MIN_PAYLOAD = 32,
  parameter int  MAX_PAYLOAD = 1024,
  parameter int  IDLE_LEN    = 15,
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_CH-1:0]  Rx_En,
  input  logic [N_CH-1:0]  Rx,
  input  logic             Cnt_Clr,
  input  logic [SEL_W-1:0] Rd_Sel,
  input  logic [1:0]       Rd_Type,
  output logic [CNT_W-1:0] Rd_Data,
  output logic [N_CH-1:0]  FlagDetect,
  output logic [N_CH-1:0]  AbortDetect,
  output logic [N_CH-1:0]  FrameOK,
  output logic [N_CH-1:0]  FrameErr,
  output logic [N_CH-1:0]  Idle,
  output logic [N_CH-1:0]  InFrame
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    FRAME = 2'd1,
    IDLE  = 2'd2
  } state_t;

  state_t           state_q   [N_CH];
  state_t           state_d   [N_CH];
  logic [3:0]       run_q     [N_CH];  // saturating ones-run length
  logic [3:0]       run_d     [N_CH];
  logic [10:0]      bits_q    [N_CH];  // bits received in FRAME, saturating
  logic [10:0]      bits_d    [N_CH];
  logic [CNT_W-1:0] cnt_good  [N_CH];
  logic [CNT_W-1:0] cnt_abort [N_CH];
  logic [CNT_W-1:0] cnt_err   [N_CH];

  logic [N_CH-1:0]  flag_ev, abort_ev, stuff_ev, ok_ev, err_ev;
  logic [CNT_W-1:0] rd_d;
  logic             sel_ok;

  // The bit count at a closing flag includes the flag's own leading 0111111,
  // so the payload is seven less.
  function automatic logic payload_legal(input logic [10:0] nbits);
    int p;
    p = int'(nbits) - 7;
    return (p >= MIN_PAYLOAD) && (p <= MAX_PAYLOAD) && (p % 8 == 0);
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                            input logic clr, input logic inc);
    if (clr)
      return '0;
    if (inc && (c != '1))
      return c + CNT_W'(1);
    return c;
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    bits_d   = bits_q;
    flag_ev  = '0;
    abort_ev = '0;
    stuff_ev = '0;
    ok_ev    = '0;
    err_ev   = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (Rx_En[ch]) begin
        flag_ev[ch]  = !Rx[ch] && (run_q[ch] == 4'd6);
        stuff_ev[ch] = !Rx[ch] && (run_q[ch] == 4'd5);
        // The run keeps growing past 6, so an abort fires once per run.
        abort_ev[ch] =  Rx[ch] && (run_q[ch] == 4'd6);

        if (Rx[ch])
          run_d[ch] = (run_q[ch] == 4'd15) ? 4'd15 : run_q[ch] + 4'd1;
        else
          run_d[ch] = 4'd0;

        if ((state_q[ch] == FRAME) && !flag_ev[ch] && !stuff_ev[ch] &&
            (bits_q[ch] != '1))
          bits_d[ch] = bits_q[ch] + 11'd1;

        if (flag_ev[ch]) begin
          state_d[ch] = FRAME;
          bits_d[ch]  = '0;
          // A count of exactly seven is an empty frame between two flags.
          if ((state_q[ch] == FRAME) && (bits_q[ch] != 11'd7)) begin
            if (payload_legal(bits_q[ch]))
              ok_ev[ch] = 1'b1;
            else
              err_ev[ch] = 1'b1;
          end
        end else if (abort_ev[ch] && (state_q[ch] == FRAME)) begin
          state_d[ch] = HUNT;
        end else if (Rx[ch] && (int'(run_d[ch]) >= IDLE_LEN) &&
                     (state_q[ch] != IDLE)) begin
          state_d[ch] = IDLE;
        end else if (!Rx[ch] && (state_q[ch] == IDLE)) begin
          state_d[ch] = HUNT;
        end
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      Idle[ch]    = (state_q[ch] == IDLE);
      InFrame[ch] = (state_q[ch] == FRAME);
    end
  end

  // Channel selects beyond the populated channels read as zero.
  assign sel_ok = (32'(Rd_Sel) < N_CH);

  always_comb begin
    rd_d = '0;
    if (sel_ok) begin
      unique case (Rd_Type)
        2'd0: rd_d = cnt_good[Rd_Sel];
        2'd1: rd_d = cnt_abort[Rd_Sel];
        2'd2: rd_d = cnt_err[Rd_Sel];
        2'd3: rd_d[1:0] = {Idle[Rd_Sel], InFrame[Rd_Sel]};
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      // NOTE: the counter arrays are cleared by reset like any other register;
      // they are few enough flops that this is not a memory macro.
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch]   <= HUNT;
        run_q[ch]     <= 4'd15;  // a high line after reset cannot look like an abort
        bits_q[ch]    <= '0;
        cnt_good[ch]  <= '0;
        cnt_abort[ch] <= '0;
        cnt_err[ch]   <= '0;
      end
      FlagDetect  <= '0;
      AbortDetect <= '0;
      FrameOK     <= '0;
      FrameErr    <= '0;
      Rd_Data     <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      bits_q  <= bits_d;
      for (int ch = 0; ch < N_CH; ch++) begin
        cnt_good[ch]  <= bump(cnt_good[ch],  Cnt_Clr, ok_ev[ch]);
        cnt_abort[ch] <= bump(cnt_abort[ch], Cnt_Clr, abort_ev[ch]);
        cnt_err[ch]   <= bump(cnt_err[ch],   Cnt_Clr, err_ev[ch]);
      end
      FlagDetect  <= flag_ev;
      AbortDetect <= abort_ev;
      FrameOK     <= ok_ev;
      FrameErr    <= err_ev;
      Rd_Data     <= rd_d;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// tb_hdlc_rx_monitor
//   Directed bench for hdlc_rx_monitor. Stimulus tasks push the pulses and read
//   data each bit is expected to produce into queues tagged with the cycle in
//   which they must appear; an independent monitor on the falling edge pops and
//   compares them against the DUT outputs, and flags any unexpected pulse.
//   Counters are built 4 bits wide so saturation is reachable quickly.
`timescale 1ns/1ps
module tb_hdlc_rx_monitor;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [N_CH-1:0]  Rx_En, Rx;
  logic             Cnt_Clr;
  logic [1:0]       Rd_Sel;
  logic [1:0]       Rd_Type;
  logic [CNT_W-1:0] Rd_Data;
  logic [N_CH-1:0]  FlagDetect, AbortDetect, FrameOK, FrameErr, Idle, InFrame;

  hdlc_rx_monitor #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx_En       (Rx_En),
    .Rx          (Rx),
    .Cnt_Clr     (Cnt_Clr),
    .Rd_Sel      (Rd_Sel),
    .Rd_Type     (Rd_Type),
    .Rd_Data     (Rd_Data),
    .FlagDetect  (FlagDetect),
    .AbortDetect (AbortDetect),
    .FrameOK     (FrameOK),
    .FrameErr    (FrameErr),
    .Idle        (Idle),
    .InFrame     (InFrame)
  );

  always #5 Clk = ~Clk;

  // Pulse vector layout: {flag[3:0], abort[3:0], ok[3:0], err[3:0]}
  typedef struct {
    int unsigned due;
    logic [15:0] ev;
  } ev_t;

  typedef struct {
    int unsigned      due;
    int               sel;
    int               typ;
    logic [CNT_W-1:0] val;
  } rd_t;

  ev_t         sb_q[$];
  rd_t         rd_q[$];
  int unsigned neg_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] mon_exp, mon_act;
  rd_t         mon_rd;
  ev_t         mon_ev;

  always @(negedge Clk) begin
    mon_act = {FlagDetect, AbortDetect, FrameOK, FrameErr};
    mon_exp = '0;
    if (sb_q.size() > 0 && sb_q[0].due == neg_cnt) begin
      mon_ev  = sb_q.pop_front();
      mon_exp = mon_ev.ev;
    end
    if (mon_exp != 16'h0 || mon_act != 16'h0)
      check($sformatf("pulses cycle %0d {flag,abort,ok,err}", neg_cnt), 32'(mon_act), 32'(mon_exp));
    if (rd_q.size() > 0 && rd_q[0].due == neg_cnt) begin
      mon_rd = rd_q.pop_front();
      check($sformatf("Rd_Data ch%0d type%0d", mon_rd.sel, mon_rd.typ),
            32'(Rd_Data), 32'(mon_rd.val));
    end
    neg_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] ev_of(input int ch, input logic f, input logic a,
                                        input logic o, input logic e);
    logic [3:0] m;
    m = 4'b0001 << ch;
    return {f ? m : 4'h0, a ? m : 4'h0, o ? m : 4'h0, e ? m : 4'h0};
  endfunction

  // One bit period: drive, let the edge sample, record what must follow.
  task automatic step(input logic [3:0] en, input logic [3:0] rx, input logic clr,
                      input logic [15:0] ev);
    ev_t e;
    Rx_En   = en;
    Rx      = rx;
    Cnt_Clr = clr;
    @(posedge Clk);
    if (ev != 16'h0) begin
      e.due = neg_cnt;
      e.ev  = ev;
      sb_q.push_back(e);
    end
    @(negedge Clk);
    Rx_En   = '0;
    Cnt_Clr = 1'b0;
  endtask

  // Disabled channels see the inverted bit, so any leak through Rx_En shows.
  task automatic send_bit(input int ch, input logic b, input logic [15:0] ev);
    logic [3:0] en, rx;
    en     = 4'b0001 << ch;
    rx     = {4{~b}};
    rx[ch] = b;
    step(en, rx, 1'b0, ev);
  endtask

  task automatic send_flag(input int ch, input logic ok, input logic err);
    send_bit(ch, 1'b0, 16'h0);
    repeat (6) send_bit(ch, 1'b1, 16'h0);
    send_bit(ch, 1'b0, ev_of(ch, 1'b1, 1'b0, ok, err));
  endtask

  task automatic send_word(input int ch, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--)
      send_bit(ch, w[i], 16'h0);
  endtask

  task automatic send_abort(input int ch, input logic clr);
    logic [3:0] en, rx;
    send_bit(ch, 1'b0, 16'h0);
    repeat (6) send_bit(ch, 1'b1, 16'h0);
    en     = 4'b0001 << ch;
    rx     = 4'h0;
    rx[ch] = 1'b1;
    step(en, rx, clr, ev_of(ch, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic send_ones_stuffed(input int ch, input int n);
    int run;
    run = 0;
    for (int i = 0; i < n; i++) begin
      send_bit(ch, 1'b1, 16'h0);
      run++;
      if (run == 5) begin
        send_bit(ch, 1'b0, 16'h0);
        run = 0;
      end
    end
  endtask

  task automatic send_all(input logic b, input logic [15:0] ev);
    step(4'hF, {4{b}}, 1'b0, ev);
  endtask

  task automatic read_exp(input int sel, input int typ, input logic [CNT_W-1:0] val);
    rd_t r;
    Rx_En   = '0;
    Rd_Sel  = 2'(sel);
    Rd_Type = 2'(typ);
    @(posedge Clk);
    r.due = neg_cnt;
    r.sel = sel;
    r.typ = typ;
    r.val = val;
    rd_q.push_back(r);
    @(negedge Clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [7:0] a5_byte;

  initial begin
    a5_byte = 8'hA5;
    Rst = 1'b1; Rx_En = '0; Rx = '0; Cnt_Clr = 1'b0; Rd_Sel = '0; Rd_Type = '0;
    repeat (3) @(negedge Clk);
    check("reset pulses/levels", 32'({FlagDetect, AbortDetect, FrameOK, FrameErr, Idle, InFrame}), 32'h0);
    check("reset Rd_Data", 32'(Rd_Data), 32'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // ch0: good 32-bit frame, then boundary payload lengths
    send_flag(0, 1'b0, 1'b0);
    send_word(0, 32'hA5A5A5A5, 32);
    send_flag(0, 1'b1, 1'b0);
    read_exp(0, 0, 4'd1);
    read_exp(0, 3, 4'd1);
    send_flag(0, 1'b0, 1'b0);                 // back-to-back flag, empty frame
    send_word(0, 32'h00A5A5A5, 24);
    send_flag(0, 1'b0, 1'b1);                 // 24 < minimum
    repeat (32) send_word(0, 32'hA5A5A5A5, 32);
    send_flag(0, 1'b1, 1'b0);                 // exactly the maximum
    repeat (32) send_word(0, 32'hA5A5A5A5, 32);
    send_word(0, 32'(a5_byte), 8);
    send_flag(0, 1'b0, 1'b1);                 // one byte over the maximum
    read_exp(0, 0, 4'd2);
    read_exp(0, 2, 4'd2);
    read_exp(0, 1, 4'd0);

    // ch1: abort inside a frame
    send_flag(1, 1'b0, 1'b0);
    send_word(1, 32'h00123456, 24);
    send_abort(1, 1'b0);
    check("ch1 InFrame after abort", 32'(InFrame[1]), 32'h0);
    read_exp(1, 1, 4'd1);
    read_exp(1, 2, 4'd0);
    read_exp(1, 3, 4'd0);

    // ch2: 0xFF x4 with stuffed zeros
    send_flag(2, 1'b0, 1'b0);
    send_ones_stuffed(2, 32);
    send_flag(2, 1'b1, 1'b0);
    read_exp(2, 0, 4'd1);
    read_exp(2, 2, 4'd0);
    read_exp(0, 3, 4'd1);                     // ch0 untouched while disabled

    // ch3: 36-bit payload, then 20 ones (abort at the 7th, idle at the 15th)
    send_flag(3, 1'b0, 1'b0);
    send_word(3, 32'hA5A5A5A5, 32);
    send_word(3, 32'h0000000A, 4);
    send_flag(3, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++)
      send_bit(3, 1'b1, (i == 7) ? ev_of(3, 1'b0, 1'b1, 1'b0, 1'b0) : 16'h0);
    check("ch3 Idle/InFrame after ones", 32'({Idle[3], InFrame[3]}), 32'h2);
    read_exp(3, 3, 4'd2);
    read_exp(3, 2, 4'd1);
    read_exp(3, 1, 4'd1);
    read_exp(3, 0, 4'd0);

    // simultaneous flags on all channels
    send_all(1'b0, 16'h0);
    repeat (6) send_all(1'b1, 16'h0);
    send_all(1'b0, 16'hF000);
    read_exp(3, 3, 4'd1);
    read_exp(1, 3, 4'd1);

    // abort counter saturation on ch1, then clear colliding with an abort
    repeat (14) send_abort(1, 1'b0);
    read_exp(1, 1, 4'hF);
    send_abort(1, 1'b0);
    read_exp(1, 1, 4'hF);
    send_abort(1, 1'b1);
    read_exp(1, 1, 4'h0);
    read_exp(0, 0, 4'h0);
    read_exp(3, 2, 4'h0);

    // reset in the middle of frames on every channel
    send_all(1'b0, 16'h0);
    repeat (6) send_all(1'b1, 16'h0);
    send_all(1'b0, 16'hF000);
    for (int i = 7; i >= 0; i--)
      send_all(a5_byte[i], 16'h0);
    read_exp(0, 3, 4'd1);
    #2;
    Rst = 1'b1;
    #1;
    check("mid-frame reset pulses/levels", 32'({FlagDetect, AbortDetect, FrameOK, FrameErr, Idle, InFrame}), 32'h0);
    check("mid-frame reset Rd_Data", 32'(Rd_Data), 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    for (int s = 0; s < N_CH; s++)
      for (int t = 0; t < 4; t++)
        read_exp(s, t, 4'd0);

    // high line right after reset: straight to IDLE, never an abort
    for (int i = 0; i < 8; i++)
      send_bit(0, 1'b1, 16'h0);
    check("ch0 Idle after reset and ones", 32'({Idle[0], InFrame[0]}), 32'h2);
    read_exp(0, 1, 4'd0);

    repeat (3) @(negedge Clk);
    check("scoreboard drained", 32'(sb_q.size() + rd_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
